hls_deadlock_detect_unit_dbnc: RTL and testbench

Per-process deadlock detection node for HLS dataflow regions, instantiated once per process. It merges the blocking dependencies arriving on its input channels and forwards them downstream, raising `dl_detect_out` when its own process ID comes back around the dependency loop. Compared with the previous detection unit, it adds a stall debounce counter, so transient backpressure never propagates as a dependency. It also adds a sticky deadlock status with the blocking channel index and a software clear.

---
 rtl/hls_dl_pkg.sv | 25 ++
 rtl/hls_dl_stall_counter.sv | 36 +++
 rtl/hls_deadlock_detect_unit_dbnc.sv | 119 +++++++++++
 tb/tb_hls_deadlock_detect_unit_dbnc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_dl_pkg.sv
// Shared definitions for the debounced HLS deadlock detection unit:
// status states, constant-width helpers and the channel priority encoder.
package hls_dl_pkg;

  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set(input logic [31:0] vec);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hls_dl_stall_counter.sv
// Saturating debounce counter: stall_active only after STALL_CYCLES
// consecutive blocked edges; any unblocked edge restarts from zero.
module hls_dl_stall_counter
  import hls_dl_pkg::*;
#(
  parameter int STALL_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic blocked_in,
  output logic stall_active
);

  localparam int CW = (clog2(STALL_CYCLES + 1) < 1) ? 1 : clog2(STALL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STALL_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!blocked_in) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // With the debounce disabled the counter never leaves zero, so bypass it.
  assign stall_active = (STALL_CYCLES == 0) ? blocked_in : (cnt_q == CNT_MAX);

endmodule

// File: rtl/hls_deadlock_detect_unit_dbnc.sv
// Per-process deadlock detection node with stall debounce, frozen dependency
// set during reporting, registered token forwarding and sticky status.
module hls_deadlock_detect_unit_dbnc
  import hls_dl_pkg::*;
#(
  parameter int PROC_NUM     = 4,
  parameter int PROC_ID      = 0,
  parameter int IN_CHAN_NUM  = 2,
  parameter int OUT_CHAN_NUM = 3,
  parameter int STALL_CYCLES = 16,
  localparam int IDXW = (clog2(OUT_CHAN_NUM) < 1) ? 1 : clog2(OUT_CHAN_NUM)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  input  logic                            dl_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic                            stall_active,
  output logic                            dl_sticky,
  output logic [IDXW-1:0]                 dl_chan_idx
);

  logic [OUT_CHAN_NUM-1:0] blk_vec;
  logic [PROC_NUM-1:0]     merged, dep;
  logic [PROC_NUM-1:0]     dep_reg_q, dep_reg_d;
  logic [OUT_CHAN_NUM-1:0] token_q, token_d;
  logic                    state_q, state_d;
  logic                    sticky_q, sticky_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    merge_gate;

  hls_dl_stall_counter #(
    .STALL_CYCLES (STALL_CYCLES)
  ) u_stall_cnt (
    .clock        (clock),
    .reset        (reset),
    .blocked_in   (|proc_dep_vld_vec),
    .stall_active (stall_active)
  );

  assign blk_vec = proc_dep_vld_vec & {OUT_CHAN_NUM{stall_active}};

  // Dependency merge; the set is frozen while a report token is not present
  // during global reporting.
  always_comb begin
    merged = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      merged = merged | (in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM] &
                         {PROC_NUM{in_chan_dep_vld_vec[i]}});
    end
  end

  assign merge_gate    = ~dl_detect_in | (|token_in_vec);
  assign dep           = merge_gate ? merged : dep_reg_q;
  assign dl_detect_out = merge_gate & dep[PROC_ID] & (|blk_vec);

  always_comb begin
    dep_reg_d = (|blk_vec) ? dep : '0;
    token_d   = (((|token_in_vec) & ~token_clear) | origin) ? blk_vec : '0;
  end

  // Status FSM: clear has priority over a fresh detection.
  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (dl_clear) begin
          sticky_d = 1'b0;
          idx_d    = '0;
        end else if (dl_detect_out) begin
          state_d  = LOCKED;
          sticky_d = 1'b1;
          idx_d    = IDXW'(lowest_set(32'(blk_vec)));
        end
      end
      default: begin
        if (dl_clear) begin
          state_d  = IDLE;
          sticky_d = 1'b0;
          idx_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dep_reg_q <= '0;
      token_q   <= '0;
      state_q   <= IDLE;
      sticky_q  <= 1'b0;
      idx_q     <= '0;
    end else begin
      dep_reg_q <= dep_reg_d;
      token_q   <= token_d;
      state_q   <= state_d;
      sticky_q  <= sticky_d;
      idx_q     <= idx_d;
    end
  end

  assign out_chan_dep_vld_vec = blk_vec;
  assign out_chan_dep_data    = dep_reg_q | (PROC_NUM'(1) << PROC_ID);
  assign token_out_vec        = token_q;
  assign dl_sticky            = sticky_q;
  assign dl_chan_idx          = idx_q;

endmodule

// File: tb/tb_hls_deadlock_detect_unit_dbnc.sv
// Scenario bench for hls_deadlock_detect_unit_dbnc; expected output
// snapshots are queued with the stimulus and popped after each sample.
module tb_hls_deadlock_detect_unit_dbnc;

  logic       clock;
  logic       reset;
  logic [2:0] proc_dep_vld_vec;
  logic [1:0] in_chan_dep_vld_vec;
  logic [7:0] in_chan_dep_data_vec;
  logic [1:0] token_in_vec;
  logic       dl_detect_in, origin, token_clear, dl_clear;
  logic [2:0] out_chan_dep_vld_vec;
  logic [3:0] out_chan_dep_data;
  logic [2:0] token_out_vec;
  logic       dl_detect_out, stall_active, dl_sticky;
  logic [1:0] dl_chan_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [14:0] v;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  hls_deadlock_detect_unit_dbnc #(
    .PROC_NUM     (4),
    .PROC_ID      (1),
    .IN_CHAN_NUM  (2),
    .OUT_CHAN_NUM (3),
    .STALL_CYCLES (4)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .proc_dep_vld_vec     (proc_dep_vld_vec),
    .in_chan_dep_vld_vec  (in_chan_dep_vld_vec),
    .in_chan_dep_data_vec (in_chan_dep_data_vec),
    .token_in_vec         (token_in_vec),
    .dl_detect_in         (dl_detect_in),
    .origin               (origin),
    .token_clear          (token_clear),
    .dl_clear             (dl_clear),
    .out_chan_dep_vld_vec (out_chan_dep_vld_vec),
    .out_chan_dep_data    (out_chan_dep_data),
    .token_out_vec        (token_out_vec),
    .dl_detect_out        (dl_detect_out),
    .stall_active         (stall_active),
    .dl_sticky            (dl_sticky),
    .dl_chan_idx          (dl_chan_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time budget");
    $fatal(1, "timeout");
  end

  // {vld, data, token, detect, stall, sticky, idx}
  function automatic logic [14:0] snap();
    return {out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec,
            dl_detect_out, stall_active, dl_sticky, dl_chan_idx};
  endfunction

  function automatic logic [14:0] mk(input logic [2:0] vld, input logic [3:0] data,
                                     input logic [2:0] tok, input logic det,
                                     input logic stl, input logic stk,
                                     input logic [1:0] idx);
    return {vld, data, tok, det, stl, stk, idx};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_all();
    reset = 1'b0;
    proc_dep_vld_vec = '0; in_chan_dep_vld_vec = '0; in_chan_dep_data_vec = '0;
    token_in_vec = '0; dl_detect_in = 1'b0; origin = 1'b0;
    token_clear = 1'b0; dl_clear = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_all();
    sb.push_back('{"reset_state", mk(3'b000, 4'b0010, 3'b000, 0, 0, 0, 2'd0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
  endtask

  task automatic test_debounce();
    reset_all();
    proc_dep_vld_vec = 3'b010;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back('{$sformatf("debounce_short_%0d", k), mk(3'b000, 4'b0010, 3'b000, 0, 0, 0, 2'd0)});
      step();
      e = sb.pop_front(); checks++;
      if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    end
    proc_dep_vld_vec = 3'b000;
    sb.push_back('{"debounce_release", mk(3'b000, 4'b0010, 3'b000, 0, 0, 0, 2'd0)});
    step();
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    // A counter that kept partial credit would fire early here.
    proc_dep_vld_vec = 3'b010;
    for (int k = 1; k <= 4; k++) begin
      sb.push_back('{$sformatf("debounce_restart_%0d", k),
                     (k == 4) ? mk(3'b010, 4'b0010, 3'b000, 0, 1, 0, 2'd0)
                              : mk(3'b000, 4'b0010, 3'b000, 0, 0, 0, 2'd0)});
      step();
      e = sb.pop_front(); checks++;
      if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    end
  endtask

  task automatic test_propagation();
    reset_all();
    proc_dep_vld_vec = 3'b010; in_chan_dep_vld_vec = 2'b01; in_chan_dep_data_vec = 8'h04;
    for (int k = 1; k <= 5; k++) begin
      if (k < 4)       sb.push_back('{$sformatf("prop_%0d", k), mk(3'b000, 4'b0010, 3'b000, 0, 0, 0, 2'd0)});
      else if (k == 4) sb.push_back('{"prop_stall", mk(3'b010, 4'b0010, 3'b000, 0, 1, 0, 2'd0)});
      else             sb.push_back('{"prop_data", mk(3'b010, 4'b0110, 3'b000, 0, 1, 0, 2'd0)});
      step();
      e = sb.pop_front(); checks++;
      if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    end
  endtask

  task automatic test_loop_detect();
    reset_all();
    proc_dep_vld_vec = 3'b110; in_chan_dep_vld_vec = 2'b11; in_chan_dep_data_vec = 8'h24;
    for (int k = 1; k <= 5; k++) begin
      if (k < 4)       sb.push_back('{$sformatf("loop_%0d", k), mk(3'b000, 4'b0010, 3'b000, 0, 0, 0, 2'd0)});
      else if (k == 4) sb.push_back('{"loop_detect", mk(3'b110, 4'b0010, 3'b000, 1, 1, 0, 2'd0)});
      else             sb.push_back('{"loop_sticky", mk(3'b110, 4'b0110, 3'b000, 1, 1, 1, 2'd1)});
      step();
      e = sb.pop_front(); checks++;
      if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    end
  endtask

  // Continues from the locked state left by test_loop_detect.
  task automatic test_hold_clear();
    dl_detect_in = 1'b1; in_chan_dep_data_vec = 8'h28;
    #1;
    sb.push_back('{"hold_comb", mk(3'b110, 4'b0110, 3'b000, 0, 1, 1, 2'd1)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    sb.push_back('{"hold_frozen", mk(3'b110, 4'b0110, 3'b000, 0, 1, 1, 2'd1)});
    step();
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    dl_clear = 1'b1;
    sb.push_back('{"clear_locked", mk(3'b110, 4'b0110, 3'b000, 0, 1, 0, 2'd0)});
    step();
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    dl_clear = 1'b0;
    sb.push_back('{"clear_idle", mk(3'b110, 4'b0110, 3'b000, 0, 1, 0, 2'd0)});
    step();
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    // Detection and clear together in IDLE: clear wins, lock one edge later.
    dl_detect_in = 1'b0; dl_clear = 1'b1;
    #1;
    sb.push_back('{"clr_vs_det_comb", mk(3'b110, 4'b0110, 3'b000, 1, 1, 0, 2'd0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    sb.push_back('{"clr_vs_det_stay", mk(3'b110, 4'b1010, 3'b000, 1, 1, 0, 2'd0)});
    step();
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    dl_clear = 1'b0;
    sb.push_back('{"relock", mk(3'b110, 4'b1010, 3'b000, 1, 1, 1, 2'd1)});
    step();
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
  endtask

  task automatic test_token();
    reset_all();
    proc_dep_vld_vec = 3'b101; origin = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k < 4)       sb.push_back('{$sformatf("tok_wait_%0d", k), mk(3'b000, 4'b0010, 3'b000, 0, 0, 0, 2'd0)});
      else if (k == 4) sb.push_back('{"tok_stall", mk(3'b101, 4'b0010, 3'b000, 0, 1, 0, 2'd0)});
      else             sb.push_back('{"tok_origin", mk(3'b101, 4'b0010, 3'b101, 0, 1, 0, 2'd0)});
      step();
      e = sb.pop_front(); checks++;
      if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    end
    origin = 1'b0; token_in_vec = 2'b10; token_clear = 1'b1;
    sb.push_back('{"tok_cleared", mk(3'b101, 4'b0010, 3'b000, 0, 1, 0, 2'd0)});
    step();
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    token_clear = 1'b0;
    sb.push_back('{"tok_forward", mk(3'b101, 4'b0010, 3'b101, 0, 1, 0, 2'd0)});
    step();
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    token_in_vec = 2'b00;
    sb.push_back('{"tok_idle", mk(3'b101, 4'b0010, 3'b000, 0, 1, 0, 2'd0)});
    step();
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
  endtask

  task automatic test_async_reset();
    reset_all();
    proc_dep_vld_vec = 3'b110; in_chan_dep_vld_vec = 2'b11; in_chan_dep_data_vec = 8'h24;
    repeat (5) step();
    sb.push_back('{"ar_locked", mk(3'b110, 4'b0110, 3'b000, 1, 1, 1, 2'd1)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    proc_dep_vld_vec = 3'b000; in_chan_dep_vld_vec = 2'b00;
    step();
    proc_dep_vld_vec = 3'b110;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back('{$sformatf("ar_stall_%0d", k), mk(3'b000, 4'b0010, 3'b000, 0, 0, 1, 2'd1)});
      step();
      e = sb.pop_front(); checks++;
      if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    end
    // Assert reset while the clock is high so no edge occurs before sampling.
    #2 reset = 1'b0;
    #1;
    sb.push_back('{"ar_immediate", mk(3'b000, 4'b0010, 3'b000, 0, 0, 0, 2'd0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    #3 reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      sb.push_back('{$sformatf("ar_fresh_%0d", k),
                     (k == 4) ? mk(3'b110, 4'b0010, 3'b000, 0, 1, 0, 2'd0)
                              : mk(3'b000, 4'b0010, 3'b000, 0, 0, 0, 2'd0)});
      step();
      e = sb.pop_front(); checks++;
      if (snap() !== e.v) begin errors++; $display("FAIL %s: got %b required %b", e.nm, snap(), e.v); end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_propagation();
    test_loop_detect();
    test_hold_clear();
    test_token();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
